// File: rtl/pwm_from_count_pkg.sv
// Shared defaults and the duty clamp used by every PWM channel.
package pwm_from_count_pkg;
  localparam int CW_DEF  = 3;
  localparam int NCH_DEF = 4;

  // Duties above one full period (2**cw) saturate to a full period.
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input int cw);
    logic [31:0] max_duty;
    max_duty = 32'd1 << cw;
    return (duty > max_duty) ? max_duty : duty;
  endfunction
endpackage

// File: rtl/pwm_from_count_pwm_channel.sv
// One PWM channel: shadow/active duty pair, pending flag and the compare.
module pwm_channel
  import pwm_from_count_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrap,
  input  logic          wr_en,
  input  logic [CW:0]   wr_duty,
  input  logic [CW-1:0] count_in,
  output logic          pwm_out,
  output logic          pending
);
  logic [CW:0] active_q, active_d;
  logic [CW:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        pwm_q, pwm_d;
  logic        apply;

  always_comb begin
    apply     = wrap & pending_q;
    active_d  = apply ? shadow_q : active_q;
    shadow_d  = wr_en ? (CW+1)'(clamp_duty(32'(wr_duty), CW)) : shadow_q;
    pending_d = pending_q;
    if (apply) pending_d = 1'b0;
    // A write is only accepted while pending_q is low, so it never races the apply.
    if (wr_en) pending_d = 1'b1;
    // Compare against the duty taking effect now so a new duty covers count 0.
    pwm_d     = ({1'b0, count_in} < active_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
  assign pending = pending_q;
endmodule

// File: rtl/pwm_from_count.sv
// Multi-channel PWM slaved to an upstream mod-2**CW counter, with
// boundary-synchronous duty updates and a sticky count-sequence check.
module pwm_from_count
  import pwm_from_count_pkg::*;
#(
  parameter int CW  = CW_DEF,
  parameter int NCH = NCH_DEF,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [CW-1:0]  count_in,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW:0]    cfg_duty,
  output logic [NCH-1:0] pwm_out,
  output logic           period_tick,
  output logic [NCH-1:0] pending,
  output logic           seq_err,
  input  logic           err_clr
);
  logic [CW-1:0]  prev_count_q, prev_count_d;
  logic           started_q, started_d;
  logic           period_tick_q, period_tick_d;
  logic           seq_err_q, seq_err_d;
  logic [CW-1:0]  count_nxt;
  logic           wrap, seq_bad;
  logic [NCH-1:0] sel, wr_en;

  always_comb begin
    for (int i = 0; i < NCH; i++) sel[i] = (cfg_ch == CHW'(i));
    // Out-of-range channel indices select nothing: ready stays high, write dropped.
    cfg_ready     = ~|(sel & pending);
    wr_en         = sel & {NCH{cfg_valid & cfg_ready}};
    count_nxt     = prev_count_q + CW'(1);
    wrap          = started_q && (prev_count_q == '1) && (count_in == '0);
    seq_bad       = started_q && (count_in != count_nxt) && (count_in != prev_count_q);
    prev_count_d  = count_in;
    started_d     = 1'b1;
    period_tick_d = wrap;
    seq_err_d     = seq_bad | (seq_err_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_count_q  <= '0;
      started_q     <= 1'b0;
      period_tick_q <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      prev_count_q  <= prev_count_d;
      started_q     <= started_d;
      period_tick_q <= period_tick_d;
      seq_err_q     <= seq_err_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_channel #(.CW(CW)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wrap     (wrap),
      .wr_en    (wr_en[g]),
      .wr_duty  (cfg_duty),
      .count_in (count_in),
      .pwm_out  (pwm_out[g]),
      .pending  (pending[g])
    );
  end

  assign period_tick = period_tick_q;
  assign seq_err     = seq_err_q;
endmodule

// File: tb/tb_pwm_from_count.sv
// Directed, table-driven check of pwm_from_count (CW=3, NCH=4).
module tb_pwm_from_count;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] count_in;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [3:0] cfg_duty;
  logic [3:0] pwm_out;
  logic       period_tick;
  logic [3:0] pending;
  logic       seq_err;
  logic       err_clr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] c;
    logic       val;
    logic [1:0] ch;
    logic [3:0] duty;
    logic       clr;
    logic       rdy;
    logic [3:0] pwm;
    logic       tick;
    logic [3:0] pend;
    logic       err;
  } vec_t;

  vec_t vq[$];

  pwm_from_count #(.CW(3), .NCH(4)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_duty(cfg_duty),
    .pwm_out(pwm_out), .period_tick(period_tick), .pending(pending),
    .seq_err(seq_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] c, input logic val, input logic [1:0] ch,
                     input logic [3:0] duty, input logic clr, input logic rdy,
                     input logic [3:0] pwm, input logic tick, input logic [3:0] pend,
                     input logic err);
    vq.push_back(vec_t'{c, val, ch, duty, clr, rdy, pwm, tick, pend, err});
  endtask

  // Idle cycle shorthand: no write, no clear, cfg_ch=0.
  task automatic idl(input logic [2:0] c, input logic rdy, input logic [3:0] pwm,
                     input logic tick, input logic [3:0] pend, input logic err);
    add(c, 0, 0, 0, 0, rdy, pwm, tick, pend, err);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] pwm, input logic tick,
                            input logic [3:0] pend, input logic err);
    chk({tag, " pwm_out"}, 32'(pwm_out), 32'(pwm));
    chk({tag, " period_tick"}, 32'(period_tick), 32'(tick));
    chk({tag, " pending"}, 32'(pending), 32'(pend));
    chk({tag, " seq_err"}, 32'(seq_err), 32'(err));
  endtask

  initial begin
    // Free-running, no config
    idl(0, 1, 0, 0, 0, 0);
    for (int c = 1; c < 8; c++) idl(3'(c), 1, 0, 0, 0, 0);
    idl(0, 1, 0, 1, 0, 0);
    idl(1, 1, 0, 0, 0, 0);
    // ch0 duty=3 mid-period
    add(2, 1, 0, 3, 0, 1, 0, 0, 1, 0);
    for (int c = 3; c < 8; c++) idl(3'(c), 0, 0, 0, 1, 0);
    idl(0, 0, 1, 1, 0, 0);
    idl(1, 1, 1, 0, 0, 0);
    idl(2, 1, 1, 0, 0, 0);
    // ch1=0, ch2=8, ch3=15 (clamped to 8)
    add(3, 1, 1, 0, 0, 1, 0, 0, 4'b0010, 0);
    add(4, 1, 2, 8, 0, 1, 0, 0, 4'b0110, 0);
    add(5, 1, 3, 15, 0, 1, 0, 0, 4'b1110, 0);
    idl(6, 1, 0, 0, 4'b1110, 0);
    idl(7, 1, 0, 0, 4'b1110, 0);
    idl(0, 1, 4'b1101, 1, 0, 0);
    idl(1, 1, 4'b1101, 0, 0, 0);
    idl(2, 1, 4'b1101, 0, 0, 0);
    idl(3, 1, 4'b1100, 0, 0, 0);
    idl(4, 1, 4'b1100, 0, 0, 0);
    // Back-to-back ch0 writes: second stalls over the wrap
    add(5, 1, 0, 5, 0, 1, 4'b1100, 0, 1, 0);
    add(6, 1, 0, 1, 0, 0, 4'b1100, 0, 1, 0);
    add(7, 1, 0, 1, 0, 0, 4'b1100, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 4'b1101, 1, 0, 0);
    add(1, 1, 0, 1, 0, 1, 4'b1101, 0, 1, 0);
    idl(2, 0, 4'b1101, 0, 1, 0);
    idl(3, 0, 4'b1101, 0, 1, 0);
    idl(4, 0, 4'b1101, 0, 1, 0);
    idl(5, 0, 4'b1100, 0, 1, 0);
    idl(6, 0, 4'b1100, 0, 1, 0);
    idl(7, 0, 4'b1100, 0, 1, 0);
    idl(0, 0, 4'b1101, 1, 0, 0);
    idl(1, 1, 4'b1100, 0, 0, 0);
    idl(2, 1, 4'b1100, 0, 0, 0);
    // Sequence errors: jump 2->5, stall 4,4, clear, set-wins
    idl(5, 1, 4'b1100, 0, 0, 1);
    idl(6, 1, 4'b1100, 0, 0, 1);
    idl(7, 1, 4'b1100, 0, 0, 1);
    idl(0, 1, 4'b1101, 1, 0, 1);
    add(1, 0, 0, 0, 1, 1, 4'b1100, 0, 0, 0);
    idl(2, 1, 4'b1100, 0, 0, 0);
    idl(3, 1, 4'b1100, 0, 0, 0);
    idl(4, 1, 4'b1100, 0, 0, 0);
    idl(4, 1, 4'b1100, 0, 0, 0);
    idl(5, 1, 4'b1100, 0, 0, 0);
    add(7, 0, 0, 0, 1, 1, 4'b1100, 0, 0, 1);
    idl(0, 1, 4'b1101, 1, 0, 1);
    add(1, 0, 0, 0, 1, 1, 4'b1100, 0, 0, 0);
    // Leave writes pending before the reset
    add(2, 1, 0, 7, 0, 1, 4'b1100, 0, 4'b0001, 0);
    add(3, 1, 1, 4, 0, 1, 4'b1100, 0, 4'b0011, 0);

    reset = 1'b1; count_in = 0; cfg_valid = 0; cfg_ch = 0; cfg_duty = 0; err_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    chk("reset cfg_ready", 32'(cfg_ready), 1);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      count_in = vq[i].c; cfg_valid = vq[i].val; cfg_ch = vq[i].ch;
      cfg_duty = vq[i].duty; err_clr = vq[i].clr;
      #1;
      chk($sformatf("v%0d cfg_ready", i), 32'(cfg_ready), 32'(vq[i].rdy));
      @(posedge clk); #1;
      check_outs($sformatf("v%0d", i), vq[i].pwm, vq[i].tick, vq[i].pend, vq[i].err);
    end

    // Mid-operation reset with writes pending: asynchronous clear
    cfg_valid = 0; cfg_ch = 0; err_clr = 0; count_in = 4;
    reset = 1'b1;
    #1;
    check_outs("async reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    // First cycle after reset starts at 4: no error, and the old duties never return
    for (int k = 0; k < 10; k++) begin
      count_in = 3'(4 + k);
      @(posedge clk); #1;
      check_outs($sformatf("post-reset c%0d", 3'(4 + k)), 0, (3'(4 + k) == 3'd0), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
